// File: rtl/act_led_pkg.sv
// Shared constants and helpers for the activity LED controller.
// Optional build macro: ACT_LED_EVENT_COUNT_EN (per-channel event counters).
package act_led_pkg;

  // Per-channel mode encoding
  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_DIRECT  = 2'b01;
  localparam logic [1:0] MODE_STRETCH = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;

  // Event counter width
  localparam int EVT_W = 16;

  // Clock cycles per 1 ms tick, never below 1
  function automatic int ms_div(input int clk_hz);
    int d;
    d = clk_hz / 1000;
    return (d < 1) ? 1 : d;
  endfunction

  // Bits needed to hold 0..max_val, never below 1
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/activity_led_chan.sv
// One activity channel: synchroniser, edge detect, hold timer, blink phase,
// mode mux and (with ACT_LED_EVENT_COUNT_EN) a saturating rise counter.
module activity_led_chan
  import act_led_pkg::*;
#(
  parameter int HOLD_MS     = 50,
  parameter int BLINK_MS    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       act,
  input  logic [1:0] mode,
  input  logic       ms_tick,
  output logic       raw_lit
`ifdef ACT_LED_EVENT_COUNT_EN
  ,
  input  logic             cnt_clr,
  output logic [EVT_W-1:0] evt_cnt
`endif
);

  localparam int HW = cnt_w(HOLD_MS);
  localparam int BW = cnt_w(BLINK_MS - 1);
  localparam logic [HW-1:0] HOLD_LD    = HW'(HOLD_MS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_q;
  logic                   synced;
  logic                   act_edge;
  logic [HW-1:0]          hold_q;
  logic                   hold_active;
  logic [BW-1:0]          bcnt_q;
  logic                   phase_q;

  assign synced      = sync_q[SYNC_STAGES-1];
  assign act_edge    = synced ^ lvl_q;
  assign hold_active = (hold_q != '0);

  // Synchroniser chain plus the edge register (also the DIRECT level source)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], act};
      lvl_q  <= synced;
    end
  end

  // Hold timer: any edge reloads (beats a same-cycle tick), ticks count down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hold_q <= '0;
    else if (act_edge)
      hold_q <= HOLD_LD;
    else if (ms_tick && hold_active)
      hold_q <= hold_q - HW'(1);
  end

  // Blink phase: starts lit on a fresh hold, flips every BLINK_MS ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      bcnt_q  <= '0;
    end else if (act_edge && !hold_active) begin
      phase_q <= 1'b1;
      bcnt_q  <= '0;
    end else if (!hold_active) begin
      phase_q <= 1'b0;
      bcnt_q  <= '0;
    end else if (ms_tick) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        bcnt_q  <= bcnt_q + BW'(1);
      end
    end
  end

  // Mode mux; mode only selects, it never feeds activity detection
  always_comb begin
    raw_lit = 1'b0;
    case (mode)
      MODE_OFF:     raw_lit = 1'b0;
      MODE_DIRECT:  raw_lit = lvl_q;
      MODE_STRETCH: raw_lit = hold_active;
      MODE_BLINK:   raw_lit = hold_active & phase_q;
      default:      raw_lit = 1'b0;
    endcase
  end

`ifdef ACT_LED_EVENT_COUNT_EN
  // Saturating count of synced rising edges; clear beats a same-cycle rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      evt_cnt <= '0;
    else if (cnt_clr)
      evt_cnt <= '0;
    else if (synced && !lvl_q && (evt_cnt != '1))
      evt_cnt <= evt_cnt + EVT_W'(1);
  end
`endif

endmodule

// File: rtl/activity_led_ctrl.sv
// Board activity LED controller: per-channel logic plus shared ms prescaler,
// PWM brightness gate and registered LED outputs.
// Optional build macro: ACT_LED_EVENT_COUNT_EN adds cnt_sel/cnt_clr/cnt_out.
module activity_led_ctrl
  import act_led_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CLK_HZ         = 50000000,
  parameter int HOLD_MS        = 50,
  parameter int BLINK_MS       = 10,
  parameter int PWM_BITS       = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic                  clk_chipset,
  input  logic                  reset_n,
  input  logic [NUM_CH-1:0]     act_in,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [NUM_CH-1:0]     led
`ifdef ACT_LED_EVENT_COUNT_EN
  ,
  input  logic [cnt_w(NUM_CH-1)-1:0] cnt_sel,
  input  logic                       cnt_clr,
  output logic [EVT_W-1:0]           cnt_out
`endif
);

  localparam int DIV   = ms_div(CLK_HZ);
  localparam int PRE_W = cnt_w(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic              POL     = (LED_ACTIVE_LOW != 0);
  localparam logic [NUM_CH-1:0] LED_OFF = {NUM_CH{POL}};

  logic [PRE_W-1:0]    presc_q;
  logic                ms_tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] bright_q;
  logic                gate;
  logic [NUM_CH-1:0]   raw_lit;

`ifdef ACT_LED_EVENT_COUNT_EN
  logic [NUM_CH-1:0][EVT_W-1:0] evt_cnt;
`endif

  assign ms_tick = (presc_q == PRE_LAST);

  // 1 ms prescaler shared by all channels
  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n)
      presc_q <= '0;
    else if (ms_tick)
      presc_q <= '0;
    else
      presc_q <= presc_q + PRE_W'(1);
  end

  // Free-running PWM counter; brightness only sampled at period end
  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt  <= '0;
      bright_q <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == '1)
        bright_q <= brightness;
    end
  end

  // All-ones is forced fully on so full brightness has no dark slot
  assign gate = (bright_q == '1) || (pwm_cnt < bright_q);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    activity_led_chan #(
      .HOLD_MS     (HOLD_MS),
      .BLINK_MS    (BLINK_MS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk     (clk_chipset),
      .rst_n   (reset_n),
      .act     (act_in[i]),
      .mode    (mode[2*i +: 2]),
      .ms_tick (ms_tick),
      .raw_lit (raw_lit[i])
`ifdef ACT_LED_EVENT_COUNT_EN
      ,
      .cnt_clr (cnt_clr),
      .evt_cnt (evt_cnt[i])
`endif
    );
  end

  // Registered LED pins with polarity applied
  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n)
      led <= LED_OFF;
    else
      led <= (raw_lit & {NUM_CH{gate}}) ^ LED_OFF;
  end

`ifdef ACT_LED_EVENT_COUNT_EN
  // Registered counter readback; out-of-range selects read zero
  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n)
      cnt_out <= '0;
    else if (32'(cnt_sel) < NUM_CH)
      cnt_out <= evt_cnt[cnt_sel];
    else
      cnt_out <= '0;
  end
`endif

endmodule

// File: doc/activity_led_ctrl.md
Name: activity_led_ctrl

Overview:
Parametrised board-level activity indicator, the successor to driving an LED straight from an inverted status pin. Takes NUM_CH asynchronous activity signals (SD_DO, PS/2 data, etc.) and drives NUM_CH LEDs, one per signal. Each channel can be set to off, direct, pulse-stretched or blinking mode, with global PWM brightness. Instantiated in the board top alongside the system core, clocked from clk_chipset.

Parameters:
NUM_CH, 4, number of activity channels/LEDs
CLK_HZ, 50000000, clk_chipset frequency; 1 ms tick period = CLK_HZ/1000 cycles
HOLD_MS, 50, stretch/blink hold time after last activity edge, in ms
BLINK_MS, 10, blink half-period in ms
PWM_BITS, 8, brightness/PWM counter width
SYNC_STAGES, 2, input synchroniser depth (>=2)
LED_ACTIVE_LOW, 1, 1 = LED pin driven low when lit

Ports:
clk_chipset  in  1  system clock
reset_n  in  1  asynchronous active-low reset
act_in  in  NUM_CH  raw asynchronous activity signals
mode  in  2*NUM_CH  per-channel mode, channel i at [2i+1:2i]
brightness  in  PWM_BITS  global brightness, 0 = dark, all-ones = full on
led  out  NUM_CH  LED pins, polarity set by LED_ACTIVE_LOW

Behaviour:
- Reset (async assert, sync release): all flops cleared; synchronisers = 0; hold counters = 0; led = inactive level (all ones if LED_ACTIVE_LOW, else 0). Mid-operation reset aborts any hold immediately.
- Sync: act_in[i] passes through SYNC_STAGES flops, then one edge register. Activity = any transition (rise or fall) of the synced value.
- Tick: shared prescaler counts 0..CLK_HZ/1000-1 and pulses ms_tick for 1 cycle on wrap.
- Hold counter per channel (width clog2(HOLD_MS+1)):
  - activity edge loads HOLD_MS;
  - else ms_tick with count != 0 decrements;
  - edge and tick in the same cycle: load wins (retrigger).
  - Counts regardless of mode.
- Blink phase per channel:
  - set to 1 when the hold counter loads from 0;
  - toggles every BLINK_MS ticks while hold != 0;
  - cleared when hold reaches 0.
- Mode encoding: 00 OFF (raw lit = 0); 01 DIRECT (raw lit = synced level); 10 STRETCH (raw lit = hold != 0); 11 BLINK (raw lit = hold != 0 AND phase).
- Mode changes take effect the next cycle and never create activity.
- PWM:
  - pwm_cnt is free-running, PWM_BITS wide, wraps.
  - brightness is latched into bright_q when pwm_cnt = all-ones (glitch-free); bright_q resets to 0.
  - gate = (bright_q == all-ones) OR (pwm_cnt < bright_q).
- Output: led[i] registered = (raw lit AND gate) XOR LED_ACTIVE_LOW.
- Latency at full brightness: act_in change to led change = SYNC_STAGES+2 clk_chipset cycles for STRETCH/DIRECT.
- Stretch duration after the last edge is between HOLD_MS-1 and HOLD_MS ms (tick phase dependent).

Optional Feature:
ACT_LED_EVENT_COUNT_EN
- Defined:
  - adds ports cnt_sel (in, clog2(NUM_CH)), cnt_clr (in, 1) and cnt_out (out, 16);
  - each channel gets a 16-bit saturating counter of rising synced edges, held at 0xFFFF once reached;
  - cnt_out = registered counter[cnt_sel], 1 cycle latency;
  - cnt_clr pulse zeroes all counters; clear wins over a simultaneous edge;
  - counters reset to 0.
- Undefined: no extra ports or counters; behaviour otherwise identical.

Decomposition:
- Package act_led_pkg: mode localparams MODE_OFF/DIRECT/STRETCH/BLINK, ms divider constant function, counter width function.
- Sub-module activity_led_chan: per-channel synchroniser, edge detect, hold counter, blink phase, mode mux, and the optional event counter. Instantiated by a generate loop.
- Top keeps the prescaler, PWM counter, brightness latch and output registers.

Test Plan:
- Reset: hold reset_n=0 with act_in toggling; LED_ACTIVE_LOW=1 → led=4'b1111. Release, no activity → led stays 4'b1111.
- STRETCH, CLK_HZ=10000 (tick every 10 cycles), HOLD_MS=5, brightness=8'hFF: single rise on act_in[0] → led[0]=0 after 4 cycles, back to 1 within 40–50 cycles after the edge.
- Retrigger: edges every 30 cycles in STRETCH → led[0] stays lit continuously; an edge coinciding with ms_tick reloads to 5.
- BLINK, BLINK_MS=1, HOLD_MS=5: one edge → led[0] toggles every 10 cycles while hold is active, ending dark.
- PWM: DIRECT with act_in high, brightness=8'h40 → lit 64 of every 256 cycles. 8'h00 → never lit. 8'hFF → always lit. A change mid-period applies only after pwm_cnt wraps.
- ACT_LED_EVENT_COUNT_EN: 3 rises on channel 2, cnt_sel=2 → cnt_out=3 after 1 cycle; 70000 rises → 0xFFFF; cnt_clr → 0.
